valu_lanes: RTL and testbench



---
 rtl/valu_lanes.sv | 188 ++++++++++++++++++
 tb/tb_valu_lanes.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/valu_lanes.sv
// Multi-lane pipelined vector ALU: one command, then vl elements streamed LANES per beat
// through a single registered result stage with mask / tail-undisturbed merge.
module valu_lanes #(
  parameter int DATA_WIDTH    = 32,
  parameter int LANES         = 4,
  parameter int MICROOP_WIDTH = 5,
  parameter int MAX_VL        = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid_i,
  output logic                          cmd_ready_o,
  input  logic [MICROOP_WIDTH-1:0]      cmd_microop_i,
  input  logic [DATA_WIDTH-1:0]         cmd_imm_i,
  input  logic [$clog2(MAX_VL):0]       cmd_vl_i,
  input  logic                          cmd_vm_i,
  input  logic                          beat_valid_i,
  output logic                          beat_ready_o,
  input  logic [LANES*DATA_WIDTH-1:0]   beat_a_i,
  input  logic [LANES*DATA_WIDTH-1:0]   beat_b_i,
  input  logic [LANES*DATA_WIDTH-1:0]   beat_old_i,
  input  logic [LANES-1:0]              beat_mask_i,
  output logic                          res_valid_o,
  input  logic                          res_ready_i,
  output logic [LANES*DATA_WIDTH-1:0]   res_data_o,
  output logic                          res_last_o,
  output logic                          busy_o,
  output logic                          illegal_o
);
  localparam int VLW = $clog2(MAX_VL) + 1;
  localparam int CW  = VLW + 1;
  localparam int SHW = $clog2(DATA_WIDTH);
  localparam int DW  = DATA_WIDTH;

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are
  // both high; valid never depends on ready, and the result register holds its
  // contents stable while res_valid_o && !res_ready_i.

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_next;

  logic [MICROOP_WIDTH-1:0] op_q;
  logic [DW-1:0]            imm_q;
  logic [VLW-1:0]           vl_q;
  logic                     vm_q;
  logic [VLW-1:0]           cnt_q;
  logic                     res_valid_q;
  logic                     res_last_q;
  logic [LANES*DW-1:0]      res_data_q;
  logic                     illegal_q;

  logic                cmd_fire;
  logic                cmd_start;
  logic                beat_fire;
  logic                res_fire;
  logic                beat_last;
  logic [LANES*DW-1:0] beat_result;

  function automatic logic is_legal(input logic [MICROOP_WIDTH-1:0] op);
    int v;
    v = int'(op);
    return (v >= 1 && v <= 17) || (v >= 19 && v <= 24);
  endfunction

  function automatic logic [DW-1:0] lane_op(input logic [MICROOP_WIDTH-1:0] op,
                                            input logic [DW-1:0] a,
                                            input logic [DW-1:0] y);
    logic [DW:0]     usum;
    logic [DW-1:0]   r;
    logic [SHW-1:0]  sh;
    logic            ovf;
    usum = {1'b0, a} + {1'b0, y};
    sh   = y[SHW-1:0];
    // Signed overflow: operands agree in sign but the wrapped sum does not.
    ovf  = (a[DW-1] == y[DW-1]) && (usum[DW-1] != a[DW-1]);
    r    = '0;
    case (int'(op))
      1, 17:   r = usum[DW-1:0];
      2:       r = a - y;
      3, 19:   r = a & y;
      4, 20:   r = a | y;
      5, 21:   r = a ^ y;
      6, 22:   r = a << sh;
      7, 23:   r = a >> sh;
      8, 24:   r = $signed(a) >>> sh;
      9:       r = {{(DW-1){1'b0}}, $signed(a) < $signed(y)};
      10:      r = {{(DW-1){1'b0}}, a < y};
      11:      r = (a < y) ? a : y;
      12:      r = ($signed(a) < $signed(y)) ? a : y;
      13:      r = (a > y) ? a : y;
      14:      r = ($signed(a) > $signed(y)) ? a : y;
      15:      r = usum[DW] ? {DW{1'b1}} : usum[DW-1:0];
      16:      r = !ovf ? usum[DW-1:0]
                        : (a[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}});
      default: r = '0;
    endcase
    return r;
  endfunction

  assign cmd_fire  = cmd_valid_i && cmd_ready_o;
  assign cmd_start = cmd_fire && is_legal(cmd_microop_i) && (cmd_vl_i != '0);
  assign beat_fire = beat_valid_i && beat_ready_o;
  assign res_fire  = res_valid_q && res_ready_i;
  assign beat_last = (CW'(cnt_q) + CW'(LANES)) >= CW'(vl_q);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [DW-1:0] a;
    logic [DW-1:0] y;
    logic [DW-1:0] old;
    logic [CW-1:0] elem;
    logic          keep_old;
    assign a        = beat_a_i[g*DW +: DW];
    assign old      = beat_old_i[g*DW +: DW];
    // Codes with the top bit set take the command immediate as second operand.
    assign y        = op_q[MICROOP_WIDTH-1] ? imm_q : beat_b_i[g*DW +: DW];
    assign elem     = CW'(cnt_q) + CW'(g);
    assign keep_old = (elem >= CW'(vl_q)) || (!vm_q && !beat_mask_i[g]);
    assign beat_result[g*DW +: DW] = keep_old ? old : lane_op(op_q, a, y);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_start) state_next = RUN;
      RUN:     if (beat_fire && beat_last) state_next = DRAIN;
      DRAIN:   if (res_fire && res_last_q) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o  = 1'b0;
    beat_ready_o = 1'b0;
    busy_o       = 1'b1;
    case (state)
      IDLE: begin
        cmd_ready_o = 1'b1;
        busy_o      = 1'b0;
      end
      RUN:     beat_ready_o = !res_valid_q || res_ready_i;
      default: beat_ready_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= '0;
      imm_q       <= '0;
      vl_q        <= '0;
      vm_q        <= 1'b0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_last_q  <= 1'b0;
      res_data_q  <= '0;
      illegal_q   <= 1'b0;
    end else begin
      illegal_q <= cmd_fire && !is_legal(cmd_microop_i);
      if (cmd_start) begin
        op_q  <= cmd_microop_i;
        imm_q <= cmd_imm_i;
        vl_q  <= cmd_vl_i;
        vm_q  <= cmd_vm_i;
        cnt_q <= '0;
      end
      // A new beat overwrites the register even when the old one drains this cycle.
      if (beat_fire) begin
        res_data_q  <= beat_result;
        res_valid_q <= 1'b1;
        res_last_q  <= beat_last;
        cnt_q       <= cnt_q + VLW'(LANES);
      end else if (res_fire) begin
        res_valid_q <= 1'b0;
        res_last_q  <= 1'b0;
      end
    end
  end

  assign res_valid_o = res_valid_q;
  assign res_last_o  = res_last_q;
  assign res_data_o  = res_data_q;
  assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_valu_lanes.sv
// Bench for valu_lanes: directed corner sequences, a table of single-op vectors and
// randomized commands scored against an arithmetic reference model.
module tb_valu_lanes;
  localparam int DW = 32;
  localparam int LN = 4;
  localparam int MW = 5;
  localparam int MV = 32;
  localparam int VW = $clog2(MV) + 1;
  localparam int BW = LN * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [MW-1:0] cmd_microop = '0;
  logic [DW-1:0] cmd_imm = '0;
  logic [VW-1:0] cmd_vl = '0;
  logic          cmd_vm = 1'b0;
  logic          beat_valid = 1'b0;
  logic          beat_ready;
  logic [BW-1:0] beat_a = '0;
  logic [BW-1:0] beat_b = '0;
  logic [BW-1:0] beat_old = '0;
  logic [LN-1:0] beat_mask = '0;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [BW-1:0] res_data;
  logic          res_last;
  logic          busy;
  logic          illegal;

  valu_lanes #(.DATA_WIDTH(DW), .LANES(LN), .MICROOP_WIDTH(MW), .MAX_VL(MV)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_microop_i(cmd_microop),
    .cmd_imm_i(cmd_imm), .cmd_vl_i(cmd_vl), .cmd_vm_i(cmd_vm),
    .beat_valid_i(beat_valid), .beat_ready_o(beat_ready), .beat_a_i(beat_a),
    .beat_b_i(beat_b), .beat_old_i(beat_old), .beat_mask_i(beat_mask),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data),
    .res_last_o(res_last), .busy_o(busy), .illegal_o(illegal)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: stalled
  logic mon_en = 1'b0;
  logic [BW-1:0] exp_q[$];
  logic          exp_last_q[$];
  logic [BW-1:0] mon_e;
  logic          mon_l;

  typedef struct {
    logic [MW-1:0] op;
    logic [DW-1:0] imm;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t vecs[18];
  int legal_ops[23] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17,
                        19, 20, 21, 22, 23, 24};

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Reference: each element computed straight from the op definition with wide integers.
  function automatic logic [DW-1:0] ref_op(input logic [MW-1:0] op, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b, input logic [DW-1:0] imm);
    logic [DW-1:0] y;
    longint sa, sb, s;
    longint unsigned ua, ub, us;
    y  = (int'(op) >= 16) ? imm : b;
    ua = a;  ub = y;
    sa = $signed(a);  sb = $signed(y);
    case (int'(op))
      1, 17:  return 32'(ua + ub);
      2:      return 32'(ua - ub);
      3, 19:  return a & y;
      4, 20:  return a | y;
      5, 21:  return a ^ y;
      6, 22:  return a << y[4:0];
      7, 23:  return a >> y[4:0];
      8, 24:  return 32'(sa >>> y[4:0]);
      9:      return (sa < sb) ? 32'd1 : 32'd0;
      10:     return (ua < ub) ? 32'd1 : 32'd0;
      11:     return (ua < ub) ? a : y;
      12:     return (sa < sb) ? a : y;
      13:     return (ua > ub) ? a : y;
      14:     return (sa > sb) ? a : y;
      15: begin
        us = ua + ub;
        return (us > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(us);
      end
      16: begin
        s = sa + sb;
        if (s > 64'sd2147483647)  return 32'h7FFF_FFFF;
        if (s < -64'sd2147483648) return 32'h8000_0000;
        return 32'(s);
      end
      default: return '0;
    endcase
  endfunction

  function automatic logic [BW-1:0] ref_beat(input logic [MW-1:0] op, input logic [DW-1:0] imm,
                                             input int vl, input logic vm, input int k,
                                             input logic [BW-1:0] a, input logic [BW-1:0] b,
                                             input logic [BW-1:0] old, input logic [LN-1:0] mask);
    logic [BW-1:0] r;
    for (int i = 0; i < LN; i++) begin
      int e;
      e = k * LN + i;
      if (e >= vl || (!vm && !mask[i])) r[i*DW +: DW] = old[i*DW +: DW];
      else r[i*DW +: DW] = ref_op(op, a[i*DW +: DW], b[i*DW +: DW], imm);
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd_val();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 40));
      2:       return 32'h7FFF_FFF0 + 32'($urandom_range(0, 31));
      default: return 32'hFFFF_FFF0 + 32'($urandom_range(0, 31));
    endcase
  endfunction

  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       res_ready = 1'b1;
      1:       res_ready = 1'($urandom_range(0, 1));
      default: res_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (mon_en && !rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got %h expected none", res_data);
      end else begin
        mon_e = exp_q.pop_front();
        mon_l = exp_last_q.pop_front();
        check("res_data", res_data, mon_e);
        check1("res_last", res_last, mon_l);
      end
    end
  end

  // Called at posedge+1 with the DUT idle; returns at posedge+1 after the accept edge.
  task automatic send_cmd(input logic [MW-1:0] op, input logic [DW-1:0] imm, input int vl,
                          input logic vm);
    cmd_valid = 1'b1;  cmd_microop = op;  cmd_imm = imm;  cmd_vl = VW'(vl);  cmd_vm = vm;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [BW-1:0] a, input logic [BW-1:0] b,
                           input logic [BW-1:0] old, input logic [LN-1:0] mask,
                           input logic [BW-1:0] exp, input logic last);
    beat_valid = 1'b1;  beat_a = a;  beat_b = b;  beat_old = old;  beat_mask = mask;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (beat_ready) begin
        exp_q.push_back(exp);
        exp_last_q.push_back(last);
        @(posedge clk);
        #1 beat_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    n_fail++;
    $display("FAIL beat_accept_timeout: got no beat_ready expected beat_ready=1");
    beat_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL done_timeout: got busy=%b pending=%0d expected idle", busy, exp_q.size());
    exp_q.delete();
    exp_last_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{5'd1,  32'h0,        32'd5,        32'd7,        32'd12};
    vecs[1]  = '{5'd2,  32'h0,        32'd3,        32'd5,        32'hFFFF_FFFE};
    vecs[2]  = '{5'd3,  32'h0,        32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000};
    vecs[3]  = '{5'd9,  32'h0,        32'hFFFF_FFFF, 32'd1,        32'd1};
    vecs[4]  = '{5'd10, 32'h0,        32'hFFFF_FFFF, 32'd1,        32'd0};
    vecs[5]  = '{5'd12, 32'h0,        32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF};
    vecs[6]  = '{5'd14, 32'h0,        32'hFFFF_FFFF, 32'd1,        32'd1};
    vecs[7]  = '{5'd11, 32'h0,        32'hFFFF_FFFF, 32'd1,        32'd1};
    vecs[8]  = '{5'd13, 32'h0,        32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF};
    vecs[9]  = '{5'd15, 32'h0,        32'hFFFF_FFF0, 32'h20,       32'hFFFF_FFFF};
    vecs[10] = '{5'd16, 32'h20,       32'h7FFF_FFF0, 32'h0,        32'h7FFF_FFFF};
    vecs[11] = '{5'd16, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0,       32'h8000_0000};
    vecs[12] = '{5'd8,  32'h0,        32'h8000_0000, 32'h24,       32'hF800_0000};
    vecs[13] = '{5'd23, 32'h1,        32'h8000_0000, 32'h5,        32'h4000_0000};
    vecs[14] = '{5'd22, 32'h21,       32'd3,        32'd4,        32'd6};
    vecs[15] = '{5'd17, 32'hFFFF_FFFF, 32'd10,      32'd100,      32'd9};
    vecs[16] = '{5'd21, 32'h0F,       32'hFF,       32'h3,        32'hF0};
    vecs[17] = '{5'd7,  32'h0,        32'h8000_0000, 32'd31,       32'd1};

    // Clock/reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check1("rst_res_valid", res_valid, 1'b0);
    check1("rst_res_last", res_last, 1'b0);
    check("rst_res_data", res_data, '0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_illegal", illegal, 1'b0);
    check1("rst_cmd_ready", cmd_ready, 1'b1);
    check1("rst_beat_ready", beat_ready, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    // vl=8 add, lane index + 100, latency and last flag
    send_cmd(5'd1, 32'h0, 8, 1'b1);
    beat_valid = 1'b1;
    beat_a = {32'd3, 32'd2, 32'd1, 32'd0};
    beat_b = {4{32'd100}};
    @(negedge clk);
    check1("t1_beat_ready", beat_ready, 1'b1);
    check1("t1_valid_before", res_valid, 1'b0);
    @(posedge clk);
    #1 beat_a = {32'd7, 32'd6, 32'd5, 32'd4};
    @(negedge clk);
    check1("t1_valid0", res_valid, 1'b1);
    check("t1_beat0", res_data, {32'd103, 32'd102, 32'd101, 32'd100});
    check1("t1_last0", res_last, 1'b0);
    @(posedge clk);
    #1 beat_valid = 1'b0;
    @(negedge clk);
    check("t1_beat1", res_data, {32'd107, 32'd106, 32'd105, 32'd104});
    check1("t1_last1", res_last, 1'b1);
    check1("t1_busy_drain", busy, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check1("t1_valid_after", res_valid, 1'b0);
    check1("t1_busy_after", busy, 1'b0);
    @(posedge clk);
    #1;

    // Masked sub with tail
    mon_en = 1'b1;
    send_cmd(5'd2, 32'h0, 6, 1'b0);
    send_beat({4{32'd10}}, {4{32'd3}}, {4{32'hAA}}, 4'b0101,
              {32'hAA, 32'd7, 32'hAA, 32'd7}, 1'b1 & 1'b0);
    send_beat({4{32'd10}}, {4{32'd3}}, {4{32'hAA}}, 4'b0101,
              {32'hAA, 32'hAA, 32'hAA, 32'd7}, 1'b1);
    wait_done();

    // Single-op vector table, broadcast to every lane
    for (int i = 0; i < 18; i++) begin
      send_cmd(vecs[i].op, vecs[i].imm, 4, 1'b1);
      send_beat({4{vecs[i].a}}, {4{vecs[i].b}}, {4{32'($urandom)}}, 4'($urandom),
                {4{vecs[i].exp}}, 1'b1);
      wait_done();
    end

    // Backpressure: result stalled three cycles while the next beat waits
    mon_en = 1'b0;
    ready_mode = 2;
    send_cmd(5'd1, 32'h0, 8, 1'b1);
    beat_valid = 1'b1;
    beat_a = {32'd4, 32'd3, 32'd2, 32'd1};
    beat_b = {4{32'd10}};
    @(negedge clk);
    check1("bp_first_ready", beat_ready, 1'b1);
    @(posedge clk);
    #1 beat_a = {32'd8, 32'd7, 32'd6, 32'd5};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check1("bp_stall_ready", beat_ready, 1'b0);
      check1("bp_stall_valid", res_valid, 1'b1);
      check("bp_stall_data", res_data, {32'd14, 32'd13, 32'd12, 32'd11});
      @(posedge clk);
      #1;
    end
    ready_mode = 0;
    @(negedge clk);
    check1("bp_release_ready", beat_ready, 1'b1);
    check("bp_release_data", res_data, {32'd14, 32'd13, 32'd12, 32'd11});
    @(posedge clk);
    #1 beat_valid = 1'b0;
    @(negedge clk);
    check("bp_second_data", res_data, {32'd18, 32'd17, 32'd16, 32'd15});
    check1("bp_second_last", res_last, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check1("bp_no_dup", res_valid, 1'b0);
    check1("bp_idle", busy, 1'b0);
    @(posedge clk);
    #1;

    // Illegal opcodes and vl=0
    for (int i = 0; i < 3; i++) begin
      logic [MW-1:0] bad;
      bad = (i == 0) ? 5'd31 : ((i == 1) ? 5'd18 : 5'd0);
      send_cmd(bad, 32'h0, 4, 1'b1);
      @(negedge clk);
      check1("illegal_pulse", illegal, 1'b1);
      check1("illegal_busy", busy, 1'b0);
      @(negedge clk);
      check1("illegal_once", illegal, 1'b0);
      @(posedge clk);
      #1;
    end
    send_cmd(5'd1, 32'h0, 0, 1'b1);
    beat_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check1("vl0_valid", res_valid, 1'b0);
      check1("vl0_busy", busy, 1'b0);
      check1("vl0_beat_ready", beat_ready, 1'b0);
      check1("vl0_illegal", illegal, 1'b0);
    end
    @(posedge clk);
    #1 beat_valid = 1'b0;

    // Reset in the middle of a command
    send_cmd(5'd1, 32'h0, 8, 1'b1);
    beat_valid = 1'b1;
    beat_a = {4{32'd1}};
    beat_b = {4{32'd1}};
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    beat_valid = 1'b0;
    @(negedge clk);
    check1("mid_rst_valid", res_valid, 1'b0);
    check1("mid_rst_cmd_ready", cmd_ready, 1'b1);
    check1("mid_rst_busy", busy, 1'b0);
    @(negedge clk);
    check1("mid_rst_quiet", res_valid, 1'b0);
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    send_cmd(5'd1, 32'h0, 4, 1'b1);
    send_beat({32'd4, 32'd3, 32'd2, 32'd1}, {4{32'd20}}, '0, '0,
              {32'd24, 32'd23, 32'd22, 32'd21}, 1'b1);
    wait_done();

    // Randomized commands against the reference model
    ready_mode = 1;
    for (int n = 0; n < 40; n++) begin
      logic [MW-1:0] op;
      logic [DW-1:0] imm;
      int            vl;
      int            nb;
      logic          vm;
      op  = MW'(legal_ops[$urandom_range(0, 22)]);
      vl  = $urandom_range(1, MV);
      vm  = 1'($urandom_range(0, 1));
      imm = rnd_val();
      nb  = (vl + LN - 1) / LN;
      send_cmd(op, imm, vl, vm);
      for (int k = 0; k < nb; k++) begin
        logic [BW-1:0] a, b, old;
        logic [LN-1:0] mask;
        for (int i = 0; i < LN; i++) begin
          a[i*DW +: DW]   = rnd_val();
          b[i*DW +: DW]   = rnd_val();
          old[i*DW +: DW] = $urandom;
        end
        mask = 4'($urandom);
        repeat ($urandom_range(0, 1)) begin
          @(posedge clk);
          #1;
        end
        send_beat(a, b, old, mask, ref_beat(op, imm, vl, vm, k, a, b, old, mask), k == nb - 1);
      end
      wait_done();
    end
    ready_mode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
